// File: rtl/refill_writer.sv
// rtl/refill_writer.sv - cache-miss refill engine: one burst read, beats steered into per-word data banks
// Optional REFILL_LAST_CHECK_EN: sticky io_err when r_last disagrees with the beat count.
module refill_writer #(
  parameter int SET_W  = 7,
  parameter int WAYS   = 8,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic [SET_W-1:0]  io_req_set,
  input  logic [WAYS-1:0]   io_req_way,
  input  logic [ADDR_W-1:0] io_req_addr,
  output logic              io_mem_ar_valid,
  input  logic              io_mem_ar_ready,
  output logic [ADDR_W-1:0] io_mem_ar_addr,
  output logic [7:0]        io_mem_ar_len,
  input  logic              io_mem_r_valid,
  output logic              io_mem_r_ready,
  input  logic [DATA_W-1:0] io_mem_r_data,
  input  logic              io_mem_r_last,
  output logic [BEATS-1:0]  io_bank_w_en,
  output logic [SET_W-1:0]  io_bank_w_set,
  output logic [WAYS-1:0]   io_bank_w_way,
  output logic [DATA_W-1:0] io_bank_w_data,
  output logic              io_busy,
  output logic              io_done,
  output logic              io_err
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFF_W  = $clog2(BEATS * DATA_W / 8);
  localparam logic [BEATS-1:0] BANK0 = BEATS'(1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} stateT;

  stateT             state;
  logic [BEAT_W-1:0] beat;
  logic [SET_W-1:0]  setQ;
  logic [WAYS-1:0]   wayQ;
  logic [ADDR_W-1:0] addrQ;
  logic              lastBeat;
  logic              beatFire;

  assign lastBeat = (beat == BEAT_W'(BEATS - 1));
  assign beatFire = (state == DATA) && io_mem_r_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      beat           <= '0;
      setQ           <= '0;
      wayQ           <= '0;
      addrQ          <= '0;
      io_bank_w_en   <= '0;
      io_bank_w_set  <= '0;
      io_bank_w_way  <= '0;
      io_bank_w_data <= '0;
    end else begin
      // Bank enables are single-cycle strobes; set/way/data simply hold between writes.
      io_bank_w_en <= '0;
      case (state)
        IDLE: begin
          if (io_req_valid) begin
            setQ  <= io_req_set;
            wayQ  <= io_req_way;
            addrQ <= {io_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            state <= ADDR;
          end
        end
        ADDR: begin
          if (io_mem_ar_ready) begin
            beat  <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (io_mem_r_valid) begin
            io_bank_w_en   <= BANK0 << beat;
            io_bank_w_set  <= setQ;
            io_bank_w_way  <= wayQ;
            io_bank_w_data <= io_mem_r_data;
            beat           <= beat + BEAT_W'(1);
            if (lastBeat) state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign io_req_ready    = (state == IDLE);
  assign io_mem_ar_valid = (state == ADDR);
  assign io_mem_ar_addr  = addrQ;
  assign io_mem_ar_len   = 8'(BEATS - 1);
  assign io_mem_r_ready  = (state == DATA);
  assign io_busy         = (state != IDLE);
  assign io_done         = (state == DONE);

`ifdef REFILL_LAST_CHECK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_err <= 1'b0;
    end else if (beatFire && (io_mem_r_last != lastBeat)) begin
      io_err <= 1'b1;
    end
  end
`else
  assign io_err = 1'b0;
`endif

  // Byte offset within the line is discarded; r_last only matters to the optional check.
  logic unusedBits;
  assign unusedBits = ^{io_req_addr[OFF_W-1:0], io_mem_r_last, beatFire};

endmodule

// File: tb/tb_refill_writer.sv
// tb/tb_refill_writer.sv - self-checking bench for refill_writer (vector table, hand sequences, random refills)
module tb_refill_writer;
  localparam int SET_W  = 7;
  localparam int WAYS   = 8;
  localparam int DATA_W = 32;
  localparam int BEATS  = 4;
  localparam int ADDR_W = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              io_req_valid = 1'b0;
  logic              io_req_ready;
  logic [SET_W-1:0]  io_req_set = '0;
  logic [WAYS-1:0]   io_req_way = '0;
  logic [ADDR_W-1:0] io_req_addr = '0;
  logic              io_mem_ar_valid;
  logic              io_mem_ar_ready = 1'b0;
  logic [ADDR_W-1:0] io_mem_ar_addr;
  logic [7:0]        io_mem_ar_len;
  logic              io_mem_r_valid = 1'b0;
  logic              io_mem_r_ready;
  logic [DATA_W-1:0] io_mem_r_data = '0;
  logic              io_mem_r_last = 1'b0;
  logic [BEATS-1:0]  io_bank_w_en;
  logic [SET_W-1:0]  io_bank_w_set;
  logic [WAYS-1:0]   io_bank_w_way;
  logic [DATA_W-1:0] io_bank_w_data;
  logic              io_busy;
  logic              io_done;
  logic              io_err;

  refill_writer #(.SET_W(SET_W), .WAYS(WAYS), .DATA_W(DATA_W), .BEATS(BEATS), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_set(io_req_set), .io_req_way(io_req_way), .io_req_addr(io_req_addr),
    .io_mem_ar_valid(io_mem_ar_valid), .io_mem_ar_ready(io_mem_ar_ready),
    .io_mem_ar_addr(io_mem_ar_addr), .io_mem_ar_len(io_mem_ar_len),
    .io_mem_r_valid(io_mem_r_valid), .io_mem_r_ready(io_mem_r_ready),
    .io_mem_r_data(io_mem_r_data), .io_mem_r_last(io_mem_r_last),
    .io_bank_w_en(io_bank_w_en), .io_bank_w_set(io_bank_w_set),
    .io_bank_w_way(io_bank_w_way), .io_bank_w_data(io_bank_w_data),
    .io_busy(io_busy), .io_done(io_done), .io_err(io_err)
  );

  always #5 clock = ~clock;

  int nChecks = 0;
  int nFail   = 0;
  bit expErr  = 1'b0;

  typedef struct {
    logic [SET_W-1:0]  set;
    logic [WAYS-1:0]   way;
    logic [ADDR_W-1:0] addr;
    int                arDelay;
    logic [15:0]       vpat;
    logic [DATA_W-1:0] base;
    int                badBeat;
    logic [ADDR_W-1:0] expAr;
  } vecT;

  vecT vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete refill. Expected bank writes follow from the handshakes the bench itself drives.
  task automatic runRefill(input logic [SET_W-1:0] set, input logic [WAYS-1:0] way,
                           input logic [ADDR_W-1:0] addr, input int arDelay,
                           input logic [15:0] vpat, input bit useRand,
                           input logic [DATA_W-1:0] base, input int badBeat,
                           input logic [ADDR_W-1:0] expAr, input bit holdNext);
    int accepted;
    int cyc;
    bit v;
    logic [DATA_W-1:0] d;
    check("req_ready_idle", io_req_ready, 1);
    io_req_valid = 1'b1;
    io_req_set   = set;
    io_req_way   = way;
    io_req_addr  = addr;
    tick();
    io_req_valid = 1'b0;
    io_req_set   = SET_W'($urandom);
    io_req_way   = WAYS'($urandom);
    io_req_addr  = $urandom;
    check("ar_valid", io_mem_ar_valid, 1);
    check("ar_addr", io_mem_ar_addr, expAr);
    check("ar_len", io_mem_ar_len, BEATS - 1);
    check("req_ready_busy", io_req_ready, 0);
    check("busy", io_busy, 1);
    for (int i = 0; i < arDelay; i++) begin
      io_mem_ar_ready = 1'b0;
      tick();
      check("ar_valid_hold", io_mem_ar_valid, 1);
      check("ar_addr_hold", io_mem_ar_addr, expAr);
      check("r_ready_in_addr", io_mem_r_ready, 0);
      check("w_en_in_addr", io_bank_w_en, 0);
    end
    io_mem_ar_ready = 1'b1;
    tick();
    io_mem_ar_ready = 1'b0;
    check("ar_valid_drop", io_mem_ar_valid, 0);
    check("r_ready_data", io_mem_r_ready, 1);
    accepted = 0;
    cyc = 0;
    while (accepted < BEATS) begin
      if (cyc > 200) begin
        check("data_phase_timeout", cyc, 0);
        break;
      end
      v = useRand ? bit'($urandom_range(1)) : ((cyc < 16) ? vpat[cyc] : 1'b1);
      d = useRand ? DATA_W'($urandom) : base + DATA_W'(accepted);
      io_mem_r_valid = v;
      io_mem_r_data  = d;
      io_mem_r_last  = v && ((accepted == BEATS - 1) != (accepted == badBeat));
`ifdef REFILL_LAST_CHECK_EN
      if (v && accepted == badBeat) expErr = 1'b1;
`endif
      tick();
      if (v) begin
        check("w_en", io_bank_w_en, 64'(1) << accepted);
        check("w_data", io_bank_w_data, d);
        check("w_set", io_bank_w_set, set);
        check("w_way", io_bank_w_way, way);
        accepted++;
      end else begin
        check("w_en_gap", io_bank_w_en, 0);
      end
      check("done", io_done, accepted == BEATS);
      check("r_ready", io_mem_r_ready, accepted != BEATS);
      cyc++;
    end
    io_mem_r_valid = 1'b0;
    io_mem_r_last  = 1'b0;
    if (holdNext) io_req_valid = 1'b1;
    tick();
    check("done_clear", io_done, 0);
    check("w_en_after", io_bank_w_en, 0);
    check("busy_after", io_busy, 0);
    check("req_ready_after", io_req_ready, 1);
    check("err", io_err, expErr);
  endtask

  initial begin
    vecs[0] = '{7'h15, 8'h04, 32'h8000_1234, 0, 16'hFFFF, 32'hA0,   -1, 32'h8000_1230};
    vecs[1] = '{7'h3F, 8'h01, 32'h0000_001C, 5, 16'hFFFF, 32'h1000, -1, 32'h0000_0010};
    vecs[2] = '{7'h7F, 8'h80, 32'h1234_5678, 1, 16'h0059, 32'h2000, -1, 32'h1234_5670};
    vecs[3] = '{7'h00, 8'hA5, 32'hFFFF_FFFF, 2, 16'hFFFF, 32'h3000, -1, 32'hFFFF_FFF0};
    vecs[4] = '{7'h42, 8'h10, 32'h4000_0008, 0, 16'hFFFF, 32'h4000,  1, 32'h4000_0000};

    repeat (3) tick();
    check("rst_req_ready", io_req_ready, 1);
    check("rst_busy", io_busy, 0);
    check("rst_w_en", io_bank_w_en, 0);
    check("rst_w_set", io_bank_w_set, 0);
    check("rst_w_way", io_bank_w_way, 0);
    check("rst_w_data", io_bank_w_data, 0);
    check("rst_done", io_done, 0);
    check("rst_err", io_err, 0);
    check("rst_ar_valid", io_mem_ar_valid, 0);
    check("rst_r_ready", io_mem_r_ready, 0);
    reset = 1'b1;
    tick();

    // Vector 1 holds its successor's request through DONE (back-to-back case).
    for (int i = 0; i < 5; i++)
      runRefill(vecs[i].set, vecs[i].way, vecs[i].addr, vecs[i].arDelay, vecs[i].vpat, 1'b0,
                vecs[i].base, vecs[i].badBeat, vecs[i].expAr, i == 1);

    // Sticky error survives a clean refill.
    runRefill(7'h11, 8'h02, 32'h0000_0040, 0, 16'hFFFF, 1'b0, 32'h5000, -1, 32'h0000_0040, 1'b0);

    // Reset mid-burst after two beats, with r_valid still asserted.
    io_req_valid = 1'b1;
    io_req_set   = 7'h09;
    io_req_way   = 8'h08;
    io_req_addr  = 32'h0000_0100;
    tick();
    io_req_valid    = 1'b0;
    io_mem_ar_ready = 1'b1;
    tick();
    io_mem_ar_ready = 1'b0;
    io_mem_r_valid  = 1'b1;
    io_mem_r_data   = 32'hBEEF_0000;
    tick();
    io_mem_r_data   = 32'hBEEF_0001;
    tick();
    check("pre_rst_w_en", io_bank_w_en, 4'b0010);
    #2 reset = 1'b0;
    #1;
    check("async_w_en", io_bank_w_en, 0);
    check("async_busy", io_busy, 0);
    check("async_ready", io_req_ready, 1);
    check("async_r_ready", io_mem_r_ready, 0);
    check("async_err", io_err, 0);
    expErr = 1'b0;
    tick();
    io_mem_r_valid = 1'b0;
    reset = 1'b1;
    tick();
    runRefill(7'h09, 8'h08, 32'h0000_0104, 0, 16'hFFFF, 1'b0, 32'hC000, -1, 32'h0000_0100, 1'b0);

    // Randomized refills against the bench's own address and write-order rules.
    for (int n = 0; n < 20; n++) begin
      logic [SET_W-1:0]  rs;
      logic [WAYS-1:0]   rw;
      logic [ADDR_W-1:0] ra;
      rs = SET_W'($urandom);
      rw = WAYS'($urandom);
      ra = $urandom;
      runRefill(rs, rw, ra, $urandom_range(3), 16'h0, 1'b1, 32'h0, -1,
                ra - (ra % (BEATS * DATA_W / 8)), n[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule

// File: doc/refill_writer.md
Name: refill_writer

Overview:
- Cache-miss refill engine sitting directly upstream of the per-word data banks.
- Accepts a refill request (set, victim way, line address) and issues one burst read to memory.
- Steers each returned beat into the data bank for that word offset, writing the victim way at the requested set.
- Signals completion to the miss handler.

Parameters:
SET_W, 7, set index width; matches bank write-set width.
WAYS, 8, associativity; width of the one-hot way vector.
DATA_W, 32, beat width and bank word width.
BEATS, 4, words per line; equals the number of data banks; power of two, at least 2.
ADDR_W, 32, memory address width.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
io_req_valid  in  1  refill request valid
io_req_ready  out  1  high only in IDLE
io_req_set  in  SET_W  target set
io_req_way  in  WAYS  one-hot victim way
io_req_addr  in  ADDR_W  miss address (any byte within the line)
io_mem_ar_valid  out  1  burst read request valid
io_mem_ar_ready  in  1  memory accepts request
io_mem_ar_addr  out  ADDR_W  line-aligned address
io_mem_ar_len  out  8  constant BEATS-1
io_mem_r_valid  in  1  read beat valid
io_mem_r_ready  out  1  high only in DATA
io_mem_r_data  in  DATA_W  beat data
io_mem_r_last  in  1  final beat marker
io_bank_w_en  out  BEATS  one-hot bank write enable
io_bank_w_set  out  SET_W  write set, common to all banks
io_bank_w_way  out  WAYS  write way, common to all banks
io_bank_w_data  out  DATA_W  write data, common to all banks
io_busy  out  1  state is not IDLE
io_done  out  1  one-cycle completion pulse
io_err  out  1  protocol error sticky flag; see Optional Feature

Behaviour:
Reset values (async on reset low): state IDLE, beat counter 0, all io_bank_w_* 0, io_done 0, io_err 0, latched set/way/addr 0.

States: IDLE, ADDR, DATA, DONE.
- IDLE
  - io_req_ready=1.
  - On io_req_valid: latch set and way, latch addr with low log2(BEATS*DATA_W/8) bits cleared, go to ADDR.
- ADDR
  - io_mem_ar_valid=1 with the latched address.
  - ar_valid, addr and len stay stable until io_mem_ar_ready, then go to DATA with beat=0.
  - ar_ready seen in the same cycle ar_valid first rises is accepted.
- DATA
  - io_mem_r_ready=1.
  - Each cycle with r_valid: register data into io_bank_w_data, set io_bank_w_en=(1<<beat), drive io_bank_w_set/way from the latches, increment beat.
  - Bank write outputs appear exactly one cycle after the beat handshake; w_en is zero in all other cycles.
  - Beat handshakes on consecutive cycles produce back-to-back writes; r_valid gaps produce no write.
  - Beat accepted with beat==BEATS-1: go to DONE. The counter wraps to 0.
- DONE
  - The last write is presented this cycle, and io_done=1 for exactly this cycle.
  - Next state is IDLE unconditionally.
  - A request arriving during DONE waits; it is accepted the following cycle.

Other rules:
- io_req_way is passed through unchanged. A non-one-hot value is not checked and writes every selected way.
- io_mem_r_last does not affect sequencing; the beat count alone ends the burst.
- Reset asserted mid-burst returns to IDLE immediately with w_en=0. Beats still in flight after reset are not consumed, because r_ready=0.

Optional Feature:
Macro REFILL_LAST_CHECK_EN.
- Defined:
  - io_err is set when r_last=1 on an accepted beat with beat!=BEATS-1.
  - io_err is also set when r_last=0 on the accepted beat with beat==BEATS-1.
  - io_err is sticky and cleared only by reset.
  - Data writes and sequencing are unchanged.
- Undefined: io_err is tied to 0 and no check logic is present.

Test Plan:
- Basic refill: req set=0x15, way=0x04, addr=0x8000_1234 -> ar_addr=0x8000_1230 and ar_len=3. Then r_data A0..A3 on consecutive cycles -> w_en 0001,0010,0100,1000 on four consecutive cycles, set=0x15, way=0x04, data A0..A3. io_done pulses with the 1000 write; io_req_ready returns high on the next cycle.
- AR backpressure: ar_ready low for 5 cycles -> ar_valid and ar_addr stable throughout, r_ready=0, no writes.
- R gaps: r_valid pattern 1,0,0,1,1,0,1 -> exactly 4 writes, each one cycle after its handshake, w_en=0 in the gap cycles.
- Back-to-back requests: second req held valid from DONE -> not accepted in DONE, accepted the next cycle, beat restarts at 0 (first write w_en=0001).
- Reset mid-burst: reset low after 2 beats -> w_en=0, busy=0, ready=1 asynchronously. A fresh refill afterwards starts at bank 0.
- With REFILL_LAST_CHECK_EN: r_last=1 on beat 1 -> io_err=1, remaining beats are still written, and io_err stays 1 until reset. Without the macro, the same stimulus leaves io_err=0.
